// File: rtl/fix_acceptor_session.sv
// FIX acceptor session: byte-serial tag/value parser, logon/heartbeat/logout
// session FSM, single-slot response queue and valid/ready byte transmitter.
module fix_acceptor_session #(
  parameter logic [15:0] HB_INTERVAL = 16'd64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       connected_i,
  input  logic [2:0] connected_host_addr_i,
  input  logic       new_message_received_i,
  input  logic [7:0] message_i,
  input  logic       send_ready_i,
  output logic       send_message_valid_o,
  output logic [7:0] message_o,
  output logic       session_active_o,
  output logic [2:0] session_host_addr_o,
  output logic       disconnect_req_o,
  output logic       parse_error_o
);

  localparam logic [7:0]  CH_SEMI  = 8'h3B;
  localparam logic [7:0]  CH_EQ    = 8'h3D;
  localparam logic [16:0] RX_LIMIT = {HB_INTERVAL, 1'b0};

  // Response codes double as priorities: larger value wins the slot.
  localparam logic [1:0] R_NONE   = 2'd0;
  localparam logic [1:0] R_HB     = 2'd1;
  localparam logic [1:0] R_ACK    = 2'd2;
  localparam logic [1:0] R_LOGOUT = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_AWAIT_LOGON, S_ACTIVE, S_CLOSING} state_t;
  typedef enum logic [1:0] {P_TAG, P_VALUE, P_SKIP} pstate_t;

  state_t      state_reg, state_next;
  logic        disconnect_reg, disconnect_next;
  logic [2:0]  host_addr_reg;

  pstate_t     p_state_reg;
  logic [9:0]  tag_reg;
  logic        first_val_reg;
  logic [7:0]  msg_type_reg;
  logic [7:0]  done_type_reg;
  logic        msg_done_reg;
  logic        parse_error_reg;

  logic        pend_valid_reg;
  logic [1:0]  pend_type_reg;
  logic        tx_busy_reg;
  logic [3:0]  tx_idx_reg;
  logic [1:0]  tx_type_reg;
  logic [7:0]  tx_byte;

  logic [15:0] tx_cnt_reg;
  logic [16:0] rx_cnt_reg;

  logic        abort;
  logic        in_idle;
  logic        tx_start;
  logic        tx_xfer;
  logic        last_byte;
  logic        hb_due;
  logic [1:0]  req;
  logic        is_digit;
  logic [13:0] tag_prod;

  assign in_idle   = (state_reg == S_IDLE);
  assign abort     = !in_idle && !connected_i;
  assign tx_start  = !tx_busy_reg && pend_valid_reg;
  assign tx_xfer   = tx_busy_reg && send_ready_i;
  assign last_byte = tx_xfer && (tx_idx_reg == 4'd11);
  assign hb_due    = (tx_cnt_reg >= HB_INTERVAL) && !pend_valid_reg && !tx_busy_reg;

  assign is_digit = (message_i >= 8'h30) && (message_i <= 8'h39);
  assign tag_prod = ({4'd0, tag_reg} * 14'd10) + {10'd0, message_i[3:0]};

  // ---------------- parser ----------------
  always_ff @(posedge clk) begin
    msg_done_reg    <= 1'b0;
    parse_error_reg <= 1'b0;
    if (reset || in_idle) begin
      p_state_reg   <= P_TAG;
      tag_reg       <= 10'd0;
      first_val_reg <= 1'b0;
      msg_type_reg  <= 8'd0;
      done_type_reg <= 8'd0;
    end else if (new_message_received_i) begin
      case (p_state_reg)
        P_TAG: begin
          if (is_digit) begin
            if (tag_prod > 14'd999) begin
              parse_error_reg <= 1'b1;
              p_state_reg     <= P_SKIP;
            end else begin
              tag_reg <= tag_prod[9:0];
            end
          end else if (message_i == CH_EQ) begin
            p_state_reg   <= P_VALUE;
            first_val_reg <= 1'b1;
          end else begin
            // A stray ';' already ends the bad field, so there is nothing to skip.
            parse_error_reg <= 1'b1;
            tag_reg         <= 10'd0;
            p_state_reg     <= (message_i == CH_SEMI) ? P_TAG : P_SKIP;
          end
        end
        P_VALUE: begin
          first_val_reg <= 1'b0;
          if (message_i == CH_SEMI) begin
            if (tag_reg == 10'd10) begin
              msg_done_reg  <= 1'b1;
              done_type_reg <= msg_type_reg;
              msg_type_reg  <= 8'd0;
            end
            tag_reg     <= 10'd0;
            p_state_reg <= P_TAG;
          end else if (first_val_reg && tag_reg == 10'd35) begin
            msg_type_reg <= message_i;
          end
        end
        default: begin
          if (message_i == CH_SEMI) begin
            tag_reg     <= 10'd0;
            p_state_reg <= P_TAG;
          end
        end
      endcase
    end
  end

  // ---------------- session FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      disconnect_reg <= 1'b0;
      host_addr_reg  <= 3'd0;
    end else begin
      state_reg      <= state_next;
      disconnect_reg <= disconnect_next;
      if (in_idle && connected_i) host_addr_reg <= connected_host_addr_i;
    end
  end

  always_comb begin
    state_next      = state_reg;
    disconnect_next = 1'b0;
    req             = R_NONE;
    case (state_reg)
      S_IDLE: begin
        if (connected_i) state_next = S_AWAIT_LOGON;
      end
      S_AWAIT_LOGON: begin
        if (msg_done_reg) begin
          if (done_type_reg == "A") begin
            req        = R_ACK;
            state_next = S_ACTIVE;
          end else begin
            req        = R_LOGOUT;
            state_next = S_CLOSING;
          end
        end
      end
      S_ACTIVE: begin
        // A completing message takes precedence over both timers this cycle.
        if (msg_done_reg) begin
          if (done_type_reg == "1") begin
            req = R_HB;
          end else if (done_type_reg == "5") begin
            req        = R_LOGOUT;
            state_next = S_CLOSING;
          end
        end else if (rx_cnt_reg >= RX_LIMIT) begin
          req        = R_LOGOUT;
          state_next = S_CLOSING;
        end else if (hb_due) begin
          req = R_HB;
        end
      end
      default: begin
        if (last_byte && tx_type_reg == R_LOGOUT) begin
          state_next      = S_IDLE;
          disconnect_next = 1'b1;
        end
      end
    endcase
    if (abort) begin
      state_next      = S_IDLE;
      disconnect_next = 1'b0;
      req             = R_NONE;
    end
  end

  // ---------------- pending-response slot ----------------
  always_ff @(posedge clk) begin
    if (reset || abort || in_idle) begin
      pend_valid_reg <= 1'b0;
      pend_type_reg  <= R_NONE;
    end else if (req != R_NONE && (!pend_valid_reg || tx_start || req > pend_type_reg)) begin
      pend_valid_reg <= 1'b1;
      pend_type_reg  <= req;
    end else if (tx_start) begin
      pend_valid_reg <= 1'b0;
    end
  end

  // ---------------- transmitter ----------------
  always_ff @(posedge clk) begin
    if (reset || abort || in_idle) begin
      tx_busy_reg <= 1'b0;
      tx_idx_reg  <= 4'd0;
      tx_type_reg <= R_NONE;
    end else if (tx_start) begin
      tx_busy_reg <= 1'b1;
      tx_idx_reg  <= 4'd0;
      tx_type_reg <= pend_type_reg;
    end else if (tx_xfer) begin
      if (tx_idx_reg == 4'd11) tx_busy_reg <= 1'b0;
      else                     tx_idx_reg  <= tx_idx_reg + 4'd1;
    end
  end

  always_comb begin
    tx_byte = 8'd0;
    case (tx_idx_reg)
      4'd0:  tx_byte = "3";
      4'd1:  tx_byte = "5";
      4'd2:  tx_byte = "=";
      4'd3:  tx_byte = (tx_type_reg == R_ACK) ? "A" : (tx_type_reg == R_LOGOUT) ? "5" : "0";
      4'd4:  tx_byte = CH_SEMI;
      4'd5:  tx_byte = "1";
      4'd6:  tx_byte = "0";
      4'd7:  tx_byte = "=";
      4'd8:  tx_byte = "0";
      4'd9:  tx_byte = (tx_type_reg == R_ACK) ? "3" : (tx_type_reg == R_LOGOUT) ? "2" : "1";
      4'd10: tx_byte = (tx_type_reg == R_ACK) ? "3" : (tx_type_reg == R_LOGOUT) ? "1" : "6";
      4'd11: tx_byte = CH_SEMI;
      default: tx_byte = 8'd0;
    endcase
  end

  // ---------------- timers ----------------
  always_ff @(posedge clk) begin
    if (reset || in_idle) begin
      tx_cnt_reg <= 16'd0;
      rx_cnt_reg <= 17'd0;
    end else begin
      if (tx_start || tx_xfer)          tx_cnt_reg <= 16'd0;
      else if (tx_cnt_reg < HB_INTERVAL) tx_cnt_reg <= tx_cnt_reg + 16'd1;

      if (msg_done_reg)               rx_cnt_reg <= 17'd0;
      else if (rx_cnt_reg < RX_LIMIT) rx_cnt_reg <= rx_cnt_reg + 17'd1;
    end
  end

  assign send_message_valid_o = tx_busy_reg;
  assign message_o            = tx_busy_reg ? tx_byte : 8'd0;
  assign session_active_o     = (state_reg == S_ACTIVE);
  assign session_host_addr_o  = host_addr_reg;
  assign disconnect_req_o     = disconnect_reg;
  assign parse_error_o        = parse_error_reg;

endmodule

// File: doc/fix_acceptor_session.md
FIX_ACCEPTOR_SESSION -- requirements
Module: fix_acceptor_session

Interface
REQ-001 SHALL have parameter HB_INTERVAL, default 64, heartbeat interval in clk cycles (16-bit, legal range 16..65535).
REQ-002 SHALL have ports: clk  in  1  clock, rising-edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 connected_i  in  1  TCP layer reports an open connection; level.
REQ-005 connected_host_addr_i  in  3  peer address, valid while connected_i=1.
REQ-006 new_message_received_i  in  1  message_i byte valid this cycle.
REQ-007 message_i  in  8  received FIX byte (ASCII; field delimiter 8'h3B ';').
REQ-008 send_ready_i  in  1  downstream accepts message_o this cycle.
REQ-009 send_message_valid_o  out  1  message_o valid.
REQ-010 message_o  out  8  transmitted FIX byte.
REQ-011 session_active_o  out  1  logon completed, session live.
REQ-012 session_host_addr_o  out  3  latched peer address.
REQ-013 disconnect_req_o  out  1  one-cycle pulse requesting TCP close.
REQ-014 parse_error_o  out  1  one-cycle pulse on malformed field.

Function
REQ-015 Parser SHALL accumulate tag digits ('0'-'9') into a 10-bit decimal value until '='; a non-digit before '=' or a tag above 999 SHALL pulse parse_error_o and skip bytes until the next ';'.
REQ-016 Parser SHALL latch the first value byte of tag 35 as msg_type; message complete SHALL be a one-cycle internal event on the ';' ending a tag-10 field.
REQ-017 Bytes received while in state IDLE SHALL be ignored, and the parser SHALL be cleared on entry to IDLE.
REQ-018 Session FSM states SHALL be IDLE, AWAIT_LOGON, ACTIVE and CLOSING.
REQ-019 In IDLE, connected_i=1 SHALL latch session_host_addr_o and enter AWAIT_LOGON the next cycle.
REQ-020 In AWAIT_LOGON, a completed message with msg_type 'A' SHALL queue a logon ack and enter ACTIVE; any other msg_type SHALL queue a logout and enter CLOSING.
REQ-021 In ACTIVE: msg_type '1' (test request) SHALL queue a heartbeat; '5' SHALL queue a logout and enter CLOSING; '0' and other types SHALL only restart the receive timer.
REQ-022 Each transmitted message SHALL be 12 bytes "35=" T ";10=" CCC ";", where CCC = three ASCII decimal digits of (sum of first 5 bytes) mod 256: logon ack T='A' CCC="033"; heartbeat T='0' CCC="016"; logout T='5' CCC="021".
REQ-023 Transmit SHALL use a valid/ready handshake: message_o and send_message_valid_o SHALL hold until send_ready_i=1, and a byte transfers only on a cycle where both are 1; the 12 bytes of one message SHALL be contiguous, with no other message interleaved.
REQ-024 A single pending-response slot SHALL hold at most one queued message; on conflict, priority SHALL be logout > logon ack > heartbeat, and a lower-priority request SHALL be dropped.
REQ-025 The transmit counter SHALL count cycles since the last transmitted byte; in ACTIVE, reaching HB_INTERVAL SHALL queue a heartbeat, and a message start SHALL reset the counter to 0.
REQ-026 The receive timer SHALL reset on every completed message; in ACTIVE, reaching 2*HB_INTERVAL with no message SHALL queue a logout and enter CLOSING.
REQ-027 A message completing in the same cycle as heartbeat-counter expiry SHALL be served first; the heartbeat SHALL then be suppressed because the counter restarts.
REQ-028 In CLOSING, after the last logout byte transfers, the block SHALL pulse disconnect_req_o for 1 cycle and return to IDLE.
REQ-029 connected_i falling in any non-IDLE state SHALL abort any transmission (send_message_valid_o=0 the next cycle), discard the pending slot, enter IDLE, and SHALL NOT pulse disconnect_req_o.
REQ-030 session_active_o SHALL be 1 exactly while the FSM is in ACTIVE.
REQ-031 The parser SHALL keep running while a transmission is in progress; receive and transmit SHALL be independent.

Reset
REQ-032 On reset=1 at a clk edge: FSM=IDLE, parser cleared, pending slot empty, both timers 0; send_message_valid_o, message_o, session_active_o, session_host_addr_o, disconnect_req_o and parse_error_o all SHALL be 0 from the following cycle.
REQ-033 Reset SHALL override every other input, including reset asserted mid-message on either side.

Verification
REQ-034 connected_i=1, addr=3'b010, receive "35=A;10=033;", send_ready_i=1 -> bytes "35=A;10=033;" on 12 consecutive cycles, session_active_o=1, session_host_addr_o=3'b010.
REQ-035 ACTIVE with no traffic -> "35=0;10=016;" starts HB_INTERVAL cycles after the last transmitted byte; with no receive traffic, logout "35=5;10=021;" follows by 2*HB_INTERVAL, then a 1-cycle disconnect_req_o pulse, then IDLE.
REQ-036 In AWAIT_LOGON receive "35=D;10=000;" -> logout sent, disconnect_req_o pulse, session_active_o never asserted.
REQ-037 send_ready_i toggling 1/0 during logon ack -> each byte held while stalled, no byte lost or duplicated, 12 transfers total.
REQ-038 connected_i dropped at byte 5 of a heartbeat -> send_message_valid_o=0 the next cycle, IDLE, no disconnect_req_o pulse.
REQ-039 Receive "3x=A;" -> parse_error_o pulses once, and the following valid "35=A;10=033;" completes logon normally.
